// File: rtl/mem_burst_reader_pkg.sv
// Shared types for mem_burst_reader. Defining MEM_BURST_READER_PARITY_EN adds a
// parity bit to every buffered beat.
package mem_burst_reader_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned BUF_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  last;
`ifdef MEM_BURST_READER_PARITY_EN
        logic                  parity;
`endif
    } buf_entry_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Small synchronous FIFO (BUF_DEPTH entries) holding returned beats; push and pop
// may coincide at any fill level.
module stream_skid_fifo
    import mem_burst_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic [WIDTH-1:0]                   push_data,
    input  logic                               pop,
    output logic [WIDTH-1:0]                   head_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     count
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = mem[rd_ptr];

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CNT_W'(BUF_DEPTH))));
    no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == '0)));

endmodule

// File: rtl/mem_burst_reader.sv
// Burst reader for a 1-cycle-latency synchronous memory, streaming beats out through
// a 2-entry buffer. Optional MEM_BURST_READER_PARITY_EN adds out_parity.
module mem_burst_reader
    import mem_burst_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done
`ifdef MEM_BURST_READER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    state_t            state, state_d;
    logic [ADDR_W-1:0] cur_addr, cur_addr_d;
    logic [LEN_W-1:0]  remaining, remaining_d;
    logic              issue_pending, issue_pending_d;
    logic              issue_last, issue_last_d;
    logic              done_d;
    logic [1:0]        buf_count;
    logic [2:0]        occupancy;
    logic              pop;
    logic              credit_ok;
    buf_entry_t        push_entry;
    buf_entry_t        head_entry;

    assign push_entry.data   = mem_read_data;
    assign push_entry.last   = issue_last;
`ifdef MEM_BURST_READER_PARITY_EN
    assign push_entry.parity = ^mem_read_data;
`endif

    stream_skid_fifo #(.WIDTH($bits(buf_entry_t))) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue_pending),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (buf_count)
    );

    assign out_valid        = (buf_count != '0);
    assign out_data         = head_entry.data;
    assign out_last         = out_valid && head_entry.last;
`ifdef MEM_BURST_READER_PARITY_EN
    assign out_parity       = head_entry.parity;
`endif
    assign pop              = out_valid && out_ready;
    assign mem_read_address = cur_addr;
    assign req_ready        = (state == IDLE) && !rst;

    // A slot freed by a same-cycle pop counts as credit; this is what allows
    // one beat per cycle with out_ready held high.
    assign occupancy = 3'(buf_count) + 3'(issue_pending);
    assign credit_ok = pop ? (occupancy < 3'(BUF_DEPTH + 1)) : (occupancy < 3'(BUF_DEPTH));

    always_comb begin
        state_d         = state;
        cur_addr_d      = cur_addr;
        remaining_d     = remaining;
        issue_pending_d = 1'b0;
        issue_last_d    = 1'b0;
        done_d          = pop && head_entry.last;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cur_addr_d  = req_addr;
                        remaining_d = req_len;
                        state_d     = BURST;
                    end
                end
            end
            BURST: begin
                if (credit_ok) begin
                    issue_pending_d = 1'b1;
                    issue_last_d    = (remaining == LEN_W'(1));
                    cur_addr_d      = cur_addr + ADDR_W'(1);
                    remaining_d     = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_entry.last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            issue_pending <= 1'b0;
            issue_last    <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_d;
            cur_addr      <= cur_addr_d;
            remaining     <= remaining_d;
            issue_pending <= issue_pending_d;
            issue_last    <= issue_last_d;
            done          <= done_d;
        end
    end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Self-checking bench for mem_burst_reader: table vectors, hand-written corner
// sequences and randomized bursts against an arithmetic memory/stream model.
module tb_mem_burst_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_addr;
    logic [5:0] req_len;
    logic [4:0] mem_read_address;
    logic [7:0] mem_read_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       done;
`ifdef MEM_BURST_READER_PARITY_EN
    logic       out_parity;
`endif

    int tests = 0;
    int fails = 0;
    int rdy_viol;

    logic [7:0] got_d[$];
    logic       got_l[$];
    logic       got_p[$];

    logic [7:0] mem [32];

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);
    end

    always @(posedge clk) begin
        if (rst) mem_read_data <= 8'h00;
        else     mem_read_data <= mem[mem_read_address];
    end

    mem_burst_reader #(.ADDR_W(5), .DATA_W(8), .LEN_W(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_len          (req_len),
        .mem_read_address (mem_read_address),
        .mem_read_data    (mem_read_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .done             (done)
`ifdef MEM_BURST_READER_PARITY_EN
        ,
        .out_parity       (out_parity)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [4:0] a, input int i);
        return 8'hA0 + 8'((int'(a) + i) % 32);
    endfunction

    // mode 0: always ready; 1: 1,0,0,1 pattern with a stall over cycles 6..10; 2: random
    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k >= 6 && k <= 10) ? 1'b0 : ((k % 4 == 0) || (k % 4 == 3));
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    // Cycle 0 is the accept cycle; returned cycle indices are relative to it.
    task automatic run_burst(input logic [4:0] a, input logic [5:0] l, input int mode,
                             output int first_k, output int last_k,
                             output int done_k, output int ndone);
        int k, wait_n, post, ndeliv, cap;
        got_d.delete(); got_l.delete(); got_p.delete();
        first_k = -1; last_k = -1; done_k = -1; ndone = 0; rdy_viol = 0;
        wait_n = 0; ndeliv = 0; post = -1; k = 0;
        while (!req_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (!req_ready) check("req_ready_wait", {31'b0, req_ready}, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        out_ready = ready_for(mode, 0);
        while (k < 400 && post != 0) begin
            @(negedge clk);
            k++;
            req_valid = 1'b0;
            out_ready = ready_for(mode, k);
            if (req_ready && !done && done_k < 0) rdy_viol++;
            if (out_valid && first_k < 0) first_k = k;
            if (mode == 1 && k >= 8 && k <= 10) begin
                cap = (ndeliv + 2 < int'(l)) ? ndeliv + 2 : int'(l);
                check("stall_addr_hold", {27'b0, mem_read_address},
                      32'((int'(a) + cap) % 32));
            end
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
`ifdef MEM_BURST_READER_PARITY_EN
                got_p.push_back(out_parity);
`endif
                if (out_last) last_k = k;
                ndeliv++;
            end
            if (done) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && post < 0) post = 2;
            else if (post > 0) post--;
        end
        if (done_k < 0) check("done_timeout", 0, 1);
        check("req_ready_low_in_burst", rdy_viol, 0);
    endtask

    task automatic check_beats(input string tag, input logic [4:0] a, input int l);
        logic [7:0] e;
        check({tag, "_count"}, got_d.size(), l);
        for (int i = 0; i < got_d.size() && i < l; i++) begin
            e = model_byte(a, i);
            check({tag, "_data"}, {24'b0, got_d[i]}, {24'b0, e});
            check({tag, "_last"}, {31'b0, got_l[i]}, (i == l - 1) ? 1 : 0);
`ifdef MEM_BURST_READER_PARITY_EN
            check({tag, "_parity"}, {31'b0, got_p[i]}, {31'b0, ^e});
`endif
        end
    endtask

    typedef struct {
        logic [4:0] addr;
        logic [5:0] len;
        int         mode;
        logic [7:0] first_d;
        logic [7:0] last_d;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   fk, lk, dk, nd, n, k;
        logic [4:0] ra;
        logic [5:0] rl;

        vecs[0] = '{5'd4,  6'd3, 0, 8'hA4, 8'hA6};
        vecs[1] = '{5'd30, 6'd4, 0, 8'hBE, 8'hA1};
        vecs[2] = '{5'd0,  6'd8, 1, 8'hA0, 8'hA7};
        vecs[3] = '{5'd31, 6'd2, 0, 8'hBF, 8'hA0};
        vecs[4] = '{5'd10, 6'd2, 2, 8'hAA, 8'hAB};
        vecs[5] = '{5'd0,  6'd1, 0, 8'hA0, 8'hA0};

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", {31'b0, req_ready}, 1);
        check("post_rst_out_valid", {31'b0, out_valid}, 0);
        check("post_rst_out_data", {24'b0, out_data}, 0);
        check("post_rst_out_last", {31'b0, out_last}, 0);
        check("post_rst_done", {31'b0, done}, 0);
        check("post_rst_addr", {27'b0, mem_read_address}, 0);

        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].addr, vecs[v].len, vecs[v].mode, fk, lk, dk, nd);
            check("vec_first_data", (got_d.size() > 0) ? {24'b0, got_d[0]} : 32'hFFFF, {24'b0, vecs[v].first_d});
            check("vec_last_data", (got_d.size() > 0) ? {24'b0, got_d[$]} : 32'hFFFF, {24'b0, vecs[v].last_d});
            check("vec_latency", fk - 1, 2);
            check("vec_done_gap", dk - lk, 1);
            check("vec_done_once", nd, 1);
            check("vec_end_addr", {27'b0, mem_read_address},
                  32'((int'(vecs[v].addr) + int'(vecs[v].len)) % 32));
            check_beats("vec", vecs[v].addr, int'(vecs[v].len));
        end

        // zero-length request: accepted, no reads, single done the next cycle
        run_burst(5'd7, 6'd0, 0, fk, lk, dk, nd);
        check("zero_len_beats", got_d.size(), 0);
        check("zero_len_no_valid", fk, -1);
        check("zero_len_done_cycle", dk, 1);
        check("zero_len_done_once", nd, 1);
        check("zero_len_addr", {27'b0, mem_read_address}, 1);

        // reset after the second beat of a 6-beat burst
        n = 0; k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        req_valid = 1'b1; req_addr = 5'd0; req_len = 6'd6; out_ready = 1'b1;
        k = 0;
        while (n < 2 && k < 50) begin
            @(negedge clk);
            k++;
            req_valid = 1'b0;
            if (out_valid && out_ready) n++;
        end
        check("midrst_beats_before", n, 2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req_ready_in_rst", {31'b0, req_ready}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'b0, out_valid}, 0);
        check("midrst_req_ready", {31'b0, req_ready}, 1);
        check("midrst_done", {31'b0, done}, 0);
        check("midrst_addr", {27'b0, mem_read_address}, 0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_no_stale_beat", {31'b0, out_valid}, 0);
        end
        run_burst(5'd10, 6'd2, 0, fk, lk, dk, nd);
        check("midrst_fresh_latency", fk - 1, 2);
        check("midrst_fresh_done_once", nd, 1);
        check_beats("midrst_fresh", 5'd10, 2);

        // randomized bursts with random backpressure
        for (int t = 0; t < 30; t++) begin
            ra = 5'($urandom_range(0, 31));
            rl = 6'($urandom_range(0, 12));
            if (t == 0) rl = 6'd63;
            run_burst(ra, rl, 2, fk, lk, dk, nd);
            check("rnd_done_once", nd, 1);
            if (rl != 0) begin
                check("rnd_latency", fk - 1, 2);
                check("rnd_done_gap", dk - lk, 1);
            end else begin
                check("rnd_zero_done_cycle", dk, 1);
            end
            check_beats("rnd", ra, int'(rl));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
